// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, register "none" and controller states.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  // A status that must stop the machine once it retires.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms for the five-stage pipeline: load/use, pending ret, branch mispredict.
module hazard_detect
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_Cnd,
  input  logic [3:0] M_icode,
  output logic       load_use,
  output logic       ret_pend,
  output logic       mispred
);

  always_comb begin
    load_use = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
               (E_dstM != RNONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    ret_pend = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    mispred  = (E_icode == IJXX) && !e_Cnd;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/bubble controller with RUN/HALTED sequencing and performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] rs_cnt
);

  logic load_use, ret_pend, mispred;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic [2:0]       cpu_stat_q, cpu_stat_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, lu_q, lu_d, mp_q, mp_d, rs_q, rs_d;

  hazard_detect u_hazard (
    .D_icode  (D_icode),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_dstM   (E_dstM),
    .e_Cnd    (e_Cnd),
    .M_icode  (M_icode),
    .load_use (load_use),
    .ret_pend (ret_pend),
    .mispred  (mispred)
  );

  // Reset forces the RUN equations even if the state register still says HALTED.
  always_comb begin
    if ((state_q == HALTED) && !reset) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end else begin
      F_stall  = load_use || ret_pend;
      D_stall  = load_use;
      // load_use keeps the D instruction, so a bubble must never coincide with the stall
      D_bubble = (mispred || ret_pend) && !load_use;
      E_bubble = mispred || load_use;
      M_bubble = is_exc(m_stat) || is_exc(W_stat);
      W_stall  = is_exc(W_stat);
    end
  end

  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    cpu_stat_d = cpu_stat_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    lu_d       = lu_q;
    mp_d       = mp_q;
    rs_d       = rs_q;
    case (state_q)
      RUN: begin
        cyc_d = cyc_q + CNT_W'(1);
        if (W_stat == SAOK) ret_d = ret_q + CNT_W'(1);
        else                ret_d = ret_q;
        if (load_use) lu_d = lu_q + CNT_W'(1);
        else          lu_d = lu_q;
        if (mispred) mp_d = mp_q + CNT_W'(1);
        else         mp_d = mp_q;
        if (ret_pend && !load_use) rs_d = rs_q + CNT_W'(1);
        else                       rs_d = rs_q;
        if (is_exc(W_stat)) begin
          state_d    = HALTED;
          halted_d   = 1'b1;
          cpu_stat_d = W_stat;
        end else begin
          state_d    = RUN;
          halted_d   = 1'b0;
          cpu_stat_d = SAOK;
        end
      end
      HALTED: begin
        state_d  = HALTED;
        halted_d = 1'b1;
      end
      default: begin
        state_d    = RUN;
        halted_d   = 1'b0;
        cpu_stat_d = SAOK;
      end
    endcase
  end

  // State, status latch and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      halted_q   <= 1'b0;
      cpu_stat_q <= SAOK;
      cyc_q      <= '0;
      ret_q      <= '0;
      lu_q       <= '0;
      mp_q       <= '0;
      rs_q       <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      cpu_stat_q <= cpu_stat_d;
      cyc_q      <= cyc_d;
      ret_q      <= ret_d;
      lu_q       <= lu_d;
      mp_q       <= mp_d;
      rs_q       <= rs_d;
    end
  end

  assign halted   = halted_q;
  assign cpu_stat = cpu_stat_q;
  assign cyc_cnt  = cyc_q;
  assign ret_cnt  = ret_q;
  assign lu_cnt   = lu_q;
  assign mp_cnt   = mp_q;
  assign rs_cnt   = rs_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with hand-computed expected values.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic        e_Cnd;
  logic [2:0]  m_stat, W_stat;
  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0]  cpu_stat;
  logic [31:0] cyc_cnt, ret_cnt, lu_cnt, mp_cnt, rs_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .cpu_stat(cpu_stat),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .lu_cnt(lu_cnt), .mp_cnt(mp_cnt), .rs_cnt(rs_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control vector order: F_stall D_stall D_bubble E_bubble M_bubble W_stall
  function automatic logic [31:0] ctl();
    return {26'd0, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
  endfunction

  task automatic idle(input logic [2:0] wst);
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
    m_stat = 3'd1; W_stat = wst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle(3'd0);
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stat", {29'd0, cpu_stat}, 32'd1);
    check("rst_cyc", cyc_cnt, 32'd0);
    check("rst_lu", lu_cnt, 32'd0);

    // load/use
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
    check("lu_ctl", ctl(), 32'b110100);
    tick();
    check("lu_cnt", lu_cnt, 32'd1);
    E_dstM = 4'hF; #1;
    check("lu_none_ctl", ctl(), 32'd0);
    tick();
    check("lu_cnt_hold", lu_cnt, 32'd1);

    // ret through D, E, M
    idle(3'd0); D_icode = 4'h9; #1;
    check("ret_d_ctl", ctl(), 32'b101000);
    tick();
    D_icode = 4'h1; E_icode = 4'h9; #1;
    check("ret_e_ctl", ctl(), 32'b101000);
    tick();
    E_icode = 4'h1; M_icode = 4'h9; #1;
    check("ret_m_ctl", ctl(), 32'b101000);
    tick();
    check("rs_cnt", rs_cnt, 32'd3);
    check("cyc_5", cyc_cnt, 32'd5);

    // mispredict
    idle(3'd0); E_icode = 4'h7; e_Cnd = 1'b0; #1;
    check("mp_ctl", ctl(), 32'b001100);
    tick();
    check("mp_cnt", mp_cnt, 32'd1);
    e_Cnd = 1'b1; #1;
    check("taken_ctl", ctl(), 32'd0);
    tick();
    check("mp_cnt_hold", mp_cnt, 32'd1);

    // load/use with pending ret: load/use wins for D
    idle(3'd0); E_icode = 4'h5; E_dstM = 4'h2; d_srcB = 4'h2; D_icode = 4'h9; #1;
    check("combo_ctl", ctl(), 32'b110100);
    tick();
    check("combo_lu", lu_cnt, 32'd2);
    check("combo_rs", rs_cnt, 32'd3);

    // retire count
    idle(3'd1);
    tick(); tick();
    check("ret_cnt", ret_cnt, 32'd2);
    check("cyc_10", cyc_cnt, 32'd10);

    // exception flows M -> W -> halt
    m_stat = 3'd3; #1;
    check("m_exc_ctl", ctl(), 32'b000010);
    tick();
    m_stat = 3'd1; W_stat = 3'd3; #1;
    check("w_exc_ctl", ctl(), 32'b000011);
    check("pre_halted", {31'd0, halted}, 32'd0);
    tick();
    check("halted", {31'd0, halted}, 32'd1);
    check("cpu_stat", {29'd0, cpu_stat}, 32'd3);
    check("cyc_last", cyc_cnt, 32'd12);
    check("ret_last", ret_cnt, 32'd3);
    idle(3'd1); #1;
    check("halt_ctl", ctl(), 32'b110111);
    for (int i = 0; i < 5; i++) tick();
    check("ret_frozen", ret_cnt, 32'd3);
    check("cyc_frozen", cyc_cnt, 32'd12);
    check("stat_hold", {29'd0, cpu_stat}, 32'd3);

    // reset out of HALTED
    idle(3'd0); reset = 1'b1; #1;
    check("rst_run_ctl", ctl(), 32'd0);
    tick();
    reset = 1'b0; #1;
    check("rst2_halted", {31'd0, halted}, 32'd0);
    check("rst2_stat", {29'd0, cpu_stat}, 32'd1);
    check("rst2_sum", cyc_cnt | ret_cnt | lu_cnt | mp_cnt | rs_cnt, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("cyc_after", cyc_cnt, 32'd10);
    check("ret_after", ret_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
